// File: rtl/pulse_train_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_CNT_W = 8;

  // A programmed length of 0 behaves as 1, so every phase lasts at least a cycle.
  function automatic int unsigned nz_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/pulse_train_down_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at 0.
module pulse_train_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload, step down, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                  cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable pulse train: N pulses of H high cycles separated by L low cycles,
// with ready/busy/done handshake and abort.
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] pulse_cnt,
  output logic             ready,
  output logic             busy,
  output logic             pulse,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] high_m1_q, high_m1_d, low_m1_q, low_m1_d;
  logic [CNT_W-1:0] hi_in_m1, lo_in_m1;

  logic             ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val, ph_cnt;
  logic             pc_load, pc_dec, pc_zero;
  logic [CNT_W-1:0] pc_cnt;
  logic             last_pulse;

  // Phase lengths minus one, straight from the inputs (used at acceptance).
  assign hi_in_m1 = CNT_W'(nz_len(32'(high_len)) - 1);
  assign lo_in_m1 = CNT_W'(nz_len(32'(low_len)) - 1);

  // The pulse counter still holds the current pulse; 1 (or 0) means this is the last.
  assign last_pulse = pc_zero || (pc_cnt == CNT_W'(1));

  pulse_train_down_counter #(.W(CNT_W)) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ph_load),
    .load_val_i(ph_val),
    .dec_i     (ph_dec),
    .cnt_o     (ph_cnt),
    .zero_o    (ph_zero)
  );

  pulse_train_down_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .load_val_i(pulse_cnt),
    .dec_i     (pc_dec),
    .cnt_o     (pc_cnt),
    .zero_o    (pc_zero)
  );

  // Next-state, config latch and counter control.
  always_comb begin
    state_d   = state_q;
    high_m1_d = high_m1_q;
    low_m1_d  = low_m1_q;
    ph_load   = 1'b0;
    ph_val    = high_m1_q;
    ph_dec    = 1'b0;
    pc_load   = 1'b0;
    pc_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          high_m1_d = hi_in_m1;
          low_m1_d  = lo_in_m1;
          pc_load   = 1'b1;
          if (pulse_cnt != '0) begin
            state_d = HIGH;
            ph_load = 1'b1;
            ph_val  = hi_in_m1;
          end else begin
            state_d = DONE;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ph_zero) begin
          pc_dec = 1'b1;
          if (last_pulse) begin
            state_d = DONE;
          end else begin
            state_d = LOW;
            ph_load = 1'b1;
            ph_val  = low_m1_q;
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ph_zero) begin
          state_d = HIGH;
          ph_load = 1'b1;
          ph_val  = high_m1_q;
        end else begin
          ph_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      high_m1_q <= '0;
      low_m1_q  <= '0;
    end else begin
      state_q   <= state_d;
      high_m1_q <= high_m1_d;
      low_m1_q  <= low_m1_d;
    end
  end

  // Outputs decode the state register only, so pulse is glitch-free.
  assign ready = (state_q == IDLE);
  assign busy  = (state_q == HIGH) || (state_q == LOW);
  assign pulse = (state_q == HIGH);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench: stimulus queues the hand-computed {ready,busy,pulse,done}
// for each cycle; a monitor compares on the falling edge.
module tb_pulse_train_generator;

  logic       clk = 1'b1;
  logic       rst;
  logic       start, abort;
  logic [7:0] high_len, low_len, pulse_cnt;
  logic       ready, busy, pulse, done;

  logic [3:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  pulse_train_generator #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .high_len (high_len),
    .low_len  (low_len),
    .pulse_cnt(pulse_cnt),
    .ready    (ready),
    .busy     (busy),
    .pulse    (pulse),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if ({ready, busy, pulse, done} !== e) begin
        errors++;
        $display("FAIL %s: got rdy/bsy/pls/dn=%b expected %b at %0t",
                 t, {ready, busy, pulse, done}, e, $time);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic s, input logic a, input logic [7:0] h,
                      input logic [7:0] l, input logic [7:0] n,
                      input logic [3:0] e, input string t);
    start = s; abort = a; high_len = h; low_len = l; pulse_cnt = n;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    high_len = '0; low_len = '0; pulse_cnt = '0;

    // reset state
    step(0, 0, 0, 0, 0, 4'b1000, "reset");
    step(0, 0, 0, 0, 0, 4'b1000, "reset");
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 4'b1000, "idle");

    // H=1 L=1 N=3
    step(1, 0, 1, 1, 3, 4'b1000, "t1_c0");
    step(0, 0, 1, 1, 3, 4'b0110, "t1_c1");
    step(0, 0, 1, 1, 3, 4'b0100, "t1_c2");
    step(0, 0, 1, 1, 3, 4'b0110, "t1_c3");
    step(0, 0, 1, 1, 3, 4'b0100, "t1_c4");
    step(0, 0, 1, 1, 3, 4'b0110, "t1_c5");
    step(0, 0, 1, 1, 3, 4'b0001, "t1_c6");
    step(0, 0, 1, 1, 3, 4'b1000, "t1_c7");

    // H=3 L=2 N=2, config changed mid-train
    step(1, 0, 3, 2, 2, 4'b1000, "t2_c0");
    step(0, 0, 3, 2, 2, 4'b0110, "t2_c1");
    step(0, 0, 7, 7, 9, 4'b0110, "t2_c2");
    step(0, 0, 7, 7, 9, 4'b0110, "t2_c3");
    step(0, 0, 7, 7, 9, 4'b0100, "t2_c4");
    step(0, 0, 7, 7, 9, 4'b0100, "t2_c5");
    step(0, 0, 7, 7, 9, 4'b0110, "t2_c6");
    step(0, 0, 7, 7, 9, 4'b0110, "t2_c7");
    step(0, 0, 7, 7, 9, 4'b0110, "t2_c8");
    step(0, 0, 7, 7, 9, 4'b0001, "t2_c9");
    step(0, 0, 7, 7, 9, 4'b1000, "t2_c10");

    // N=0
    step(1, 0, 5, 5, 0, 4'b1000, "n0_c0");
    step(0, 0, 5, 5, 0, 4'b0001, "n0_c1");
    step(0, 0, 5, 5, 0, 4'b1000, "n0_c2");

    // H=0 L=0 N=2 behaves as H=1 L=1
    step(1, 0, 0, 0, 2, 4'b1000, "z_c0");
    step(0, 0, 0, 0, 2, 4'b0110, "z_c1");
    step(0, 0, 0, 0, 2, 4'b0100, "z_c2");
    step(0, 0, 0, 0, 2, 4'b0110, "z_c3");
    step(0, 0, 0, 0, 2, 4'b0001, "z_c4");
    step(0, 0, 0, 0, 2, 4'b1000, "z_c5");

    // abort in 2nd LOW cycle of H=2 L=4 N=4
    step(1, 0, 2, 4, 4, 4'b1000, "ab_c0");
    step(0, 0, 2, 4, 4, 4'b0110, "ab_c1");
    step(0, 0, 2, 4, 4, 4'b0110, "ab_c2");
    step(0, 0, 2, 4, 4, 4'b0100, "ab_c3");
    step(0, 1, 2, 4, 4, 4'b0100, "ab_c4");
    step(0, 0, 2, 4, 4, 4'b1000, "ab_c5");
    step(0, 0, 2, 4, 4, 4'b1000, "ab_c6");
    step(0, 0, 2, 4, 4, 4'b1000, "ab_c7");

    // abort+start together in IDLE is not accepted
    step(1, 1, 2, 2, 2, 4'b1000, "abst_c0");
    step(0, 0, 2, 2, 2, 4'b1000, "abst_c1");

    // abort during HIGH
    step(1, 0, 3, 1, 1, 4'b1000, "abh_c0");
    step(0, 1, 3, 1, 1, 4'b0110, "abh_c1");
    step(0, 0, 3, 1, 1, 4'b1000, "abh_c2");

    // abort during DONE: done already shown, train just ends
    step(1, 0, 1, 1, 1, 4'b1000, "abd_c0");
    step(0, 0, 1, 1, 1, 4'b0110, "abd_c1");
    step(0, 1, 1, 1, 1, 4'b0001, "abd_c2");
    step(0, 0, 1, 1, 1, 4'b1000, "abd_c3");

    // start held high, H=1 L=1 N=1: restart every 3 cycles
    step(1, 0, 1, 1, 1, 4'b1000, "hold_c0");
    step(1, 0, 1, 1, 1, 4'b0110, "hold_c1");
    step(1, 0, 1, 1, 1, 4'b0001, "hold_c2");
    step(1, 0, 1, 1, 1, 4'b1000, "hold_c3");
    step(1, 0, 1, 1, 1, 4'b0110, "hold_c4");
    step(1, 0, 1, 1, 1, 4'b0001, "hold_c5");
    step(1, 0, 1, 1, 1, 4'b1000, "hold_c6");
    step(0, 0, 1, 1, 1, 4'b0110, "hold_c7");
    step(0, 0, 1, 1, 1, 4'b0001, "hold_c8");
    step(0, 0, 1, 1, 1, 4'b1000, "hold_c9");

    // asynchronous reset mid-HIGH: outputs clear before any clock edge
    step(1, 0, 4, 1, 2, 4'b1000, "ar_c0");
    step(0, 0, 4, 1, 2, 4'b0110, "ar_c1");
    rst = 1'b0;
    #1;
    step(0, 0, 4, 1, 2, 4'b1000, "ar_async");
    step(0, 0, 4, 1, 2, 4'b1000, "ar_hold");
    rst = 1'b1;
    step(1, 0, 1, 1, 1, 4'b1000, "ar_new_c0");
    step(0, 0, 1, 1, 1, 4'b0110, "ar_new_c1");
    step(0, 0, 1, 1, 1, 4'b0001, "ar_new_c2");
    step(0, 0, 1, 1, 1, 4'b1000, "ar_new_c3");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
Transmit-side companion to the team's edge and one-cycle-pulse detectors. On an accepted start request it drives a programmable train of clean, single-bit pulses: pulse_cnt pulses, each high_len cycles high, separated by low_len cycles low. Used to stimulate and handshake with detector logic, and as a strobe source for downstream blocks. Busy/ready/done provide a simple request/complete handshake.

Parameters:
CNT_W, 8, width of the high_len, low_len and pulse_cnt fields and of the internal counters.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request; accepted only when start=1 and ready=1 at a rising edge
abort  input  1  terminate the train; takes effect at the next rising edge
high_len  input  CNT_W  high-phase length in cycles; sampled at start acceptance
low_len  input  CNT_W  low-phase (gap) length in cycles; sampled at start acceptance
pulse_cnt  input  CNT_W  number of pulses; sampled at start acceptance
ready  output  1  1 in IDLE only
busy  output  1  1 in HIGH or LOW state
pulse  output  1  generated pulse train; decoded from the state register (HIGH), glitch-free
done  output  1  one-cycle strobe after the train completes normally

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, busy=0, pulse=0, done=0, all counters=0. Deassertion of rst is synchronised externally.
- States: IDLE, HIGH, LOW, DONE. Encoding is a package enum.
- Config latch: high_len, low_len and pulse_cnt are registered on acceptance. Input changes during a train have no effect.
- Zero handling: high_len=0 is treated as 1. low_len=0 is treated as 1, so consecutive pulses always have at least one low cycle.
- IDLE: start accepted at edge k.
  - pulse_cnt≠0: HIGH from cycle k+1, so pulse=1 starting one cycle after acceptance (latency 1).
  - pulse_cnt=0: go to DONE; done=1 in cycle k+1; pulse never asserts.
- HIGH: stays high_len cycles.
  - More pulses remain: go to LOW.
  - Last pulse: go to DONE. No trailing gap after the final pulse.
- LOW: stays low_len cycles, then returns to HIGH. The remaining-pulse counter decrements once per completed HIGH phase.
- DONE: lasts exactly 1 cycle with done=1, ready=0, busy=0, then goes to IDLE.
- A start asserted during DONE is ignored. It is accepted only once ready=1 again, so back-to-back trains have at least 1 idle cycle between them.
- Abort: in HIGH, LOW or DONE, the next state is IDLE.
  - pulse drops in the same next cycle.
  - done is NOT asserted on abort, including an abort during DONE, which suppresses nothing already shown.
  - In IDLE, abort is ignored except that abort=1 blocks acceptance of a simultaneous start (abort has priority).
- Total train length for N≥1 pulses: N·H + (N−1)·L cycles of busy, followed by 1 done cycle.
- Counters:
  - Phase counter is CNT_W bits, loaded with length−1 and counting down to 0.
  - Pulse counter is CNT_W bits, loaded with pulse_cnt.
  - No wrap-around is possible, because each counter is reloaded before it underflows.
- Reset mid-train: immediate return to reset values, with no done strobe.

Decomposition:
- Package pulse_train_pkg holds:
  - state_t enum (IDLE, HIGH, LOW, DONE);
  - localparam DEFAULT_CNT_W = 8;
  - a function that maps length 0 to 1.
- One natural sub-module: pulse_train_down_counter. It is a loadable CNT_W down-counter with a zero flag and is instantiated twice (phase counter and pulse counter).
- The FSM stays in the top module.

Test Plan:
- H=1, L=1, N=3, start at cycle 0 -> pulse = 0,1,0,1,0,1,0 over cycles 0..6; done=1 in cycle 6; ready=1 in cycle 7.
- H=3, L=2, N=2 -> pulse high in cycles 1-3 and 6-8; busy high in cycles 1-8; done in cycle 9; config inputs changed at cycle 2 have no effect.
- N=0 -> pulse stays 0; done=1 in cycle 1; ready=0 in cycle 1 only. Also H=0, L=0, N=2 -> behaves as H=1, L=1.
- Abort in the 2nd LOW cycle of H=2, L=4, N=4 -> pulse=0 and ready=1 the next cycle; done never asserts. Abort+start together in IDLE -> not accepted, ready stays 1.
- Start held high continuously with H=1, L=1, N=1 -> trains restart every 3 cycles (HIGH, DONE, IDLE accept); no start is accepted during DONE.
- rst asserted asynchronously mid-HIGH -> pulse, busy and done drop to 0 and ready rises to 1 immediately, without waiting for a clock edge; after release, a new start behaves normally.
